// File: rtl/jpeg_spi_pkg.sv
// Shared opcodes and FSM state encoding for the JPEG SPI slave transmitter.
package jpeg_spi_pkg;
  localparam logic [7:0] SPI_CMD_READ   = 8'h0B;
  localparam logic [7:0] SPI_CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {IDLE, CMD, STREAM, STATUS, DUMMY} spi_state_e;
endpackage

// File: rtl/jpeg_spi_slave_tx_sync.sv
// Pad synchroniser (SYNC_STAGES flops) followed by a one-flop edge detector.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the pad's idle level so no phantom edge appears after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/jpeg_spi_slave_tx.sv
// SPI mode-0 slave streaming JPEG bytes from the sequencer onto MISO.
// Optional status command/ready flag enabled by defining JPEG_SPI_STATUS_EN.
module jpeg_spi_slave_tx
  import jpeg_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_READ    = SPI_CMD_READ,
  parameter logic [7:0] CMD_STATUS  = SPI_CMD_STATUS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       je_done,
  input  logic [7:0] spi_data,
  output logic       spi_rd,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       busy
);
  spi_state_e state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] rx, rx_nxt, shreg, shreg_nxt, cmd_byte;
  logic       rd_nxt;
  logic       sck_rise, sck_fall, cs_rise, cs_fall, cs_level, mosi_s;
  logic       sck_level_unused, mosi_rise_unused, mosi_fall_unused, rx_msb_unused;
  logic       ready;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d(spi_sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  assign cmd_byte      = {rx[6:0], mosi_s};
  assign rx_msb_unused = rx[7];
  assign spi_miso      = shreg[7];
  assign busy          = ~cs_level;

  // cs events outrank any SCK edge landing in the same clk.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    rx_nxt      = rx;
    shreg_nxt   = shreg;
    rd_nxt      = 1'b0;
    if (cs_rise) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd0;
      shreg_nxt   = 8'h00;
    end else if (cs_fall) begin
      state_nxt   = CMD;
      bit_cnt_nxt = 3'd0;
      shreg_nxt   = 8'h00;
    end else if (state != IDLE) begin
      if (sck_rise) begin
        rx_nxt      = cmd_byte;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            CMD: begin
              if (cmd_byte == CMD_READ) begin
                state_nxt = STREAM;
                shreg_nxt = spi_data;
                rd_nxt    = 1'b1;
              end
`ifdef JPEG_SPI_STATUS_EN
              else if (cmd_byte == CMD_STATUS) begin
                state_nxt = STATUS;
                shreg_nxt = {7'b0, ready};
              end
`endif
              else begin
                state_nxt = DUMMY;
                shreg_nxt = 8'h00;
              end
            end
            STREAM: begin
              shreg_nxt = spi_data;
              rd_nxt    = 1'b1;
            end
`ifdef JPEG_SPI_STATUS_EN
            STATUS:  shreg_nxt = {7'b0, ready};
`endif
            default: shreg_nxt = 8'h00;
          endcase
        end
      end else if (sck_fall && bit_cnt != 3'd0) begin
        shreg_nxt = {shreg[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      rx      <= 8'h00;
      shreg   <= 8'h00;
      spi_rd  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      rx      <= rx_nxt;
      shreg   <= shreg_nxt;
      spi_rd  <= rd_nxt;
    end
  end

`ifdef JPEG_SPI_STATUS_EN
  // je_done wins over the end-of-stream clear.
  always_ff @(posedge clk) begin
    if (reset)
      ready <= 1'b0;
    else if (je_done)
      ready <= 1'b1;
    else if (cs_rise && state == STREAM)
      ready <= 1'b0;
  end
`else
  logic       je_done_unused;
  logic [7:0] cmd_status_unused;
  assign ready             = 1'b0;
  assign je_done_unused    = je_done | ready;
  assign cmd_status_unused = CMD_STATUS;
`endif
endmodule
